frame_sync_packer: RTL and testbench
====================================

Name: frame_sync_packer

Overview:
- Sits directly downstream of the differential decoder.
- Consumes the decoded bit stream, one bit per AXIS beat in tdata[0].
- Hunts for a sync word, with tolerance for a set number of bit errors. Then reads an 8-bit length byte, packs the payload bits MSB-first into bytes, and emits them on an AXIS master with tlast on the final payload byte.

Parameters:
- C_S00_AXIS_TDATA_WIDTH, 32, input stream width; only bit 0 is used.
- C_M00_AXIS_TDATA_WIDTH, 32, output stream width; byte in [7:0], upper bits zero.
- SYNC_LEN, 32, sync word length in bits (8..32).
- SYNC_WORD, 32'h1ACF_FC1D, sync pattern; the low SYNC_LEN bits are used, MSB received first.
- MAX_ERR, 2, maximum Hamming distance still accepted as sync.

Ports:
- s00_axis_aclk  in  1  single clock; all logic on its rising edge.
- s00_axis_aresetn  in  1  synchronous, active-high reset (1 = reset), despite the name.
- s00_axis_tvalid  in  1  input bit valid.
- s00_axis_tdata  in  C_S00_AXIS_TDATA_WIDTH  decoded bit in [0].
- s00_axis_tstrb  in  C_S00_AXIS_TDATA_WIDTH/8  ignored.
- s00_axis_tlast  in  1  ignored.
- s00_axis_tready  out  1  input accept.
- m00_axis_tready  in  1  downstream accept.
- m00_axis_tvalid  out  1  output byte valid.
- m00_axis_tlast  out  1  last payload byte of the frame.
- m00_axis_tdata  out  C_M00_AXIS_TDATA_WIDTH  {24'b0, byte}.
- m00_axis_tstrb  out  C_M00_AXIS_TDATA_WIDTH/8  constant 4'b0001.

Behaviour:
- **Reset (synchronous, active-high).** Effective the cycle after a sampled high: state=HUNT, shift register=0, bit count=0, byte count=0, m00_axis_tvalid=0, tlast=0, tdata=0. A reset mid-frame drops the partial frame. Any held output beat is discarded.
- **Handshakes.**
  - in_hs = s00_axis_tvalid & s00_axis_tready.
  - out_hs = m00_axis_tvalid & m00_axis_tready.
  - s00_axis_tready = ~m00_axis_tvalid | m00_axis_tready. This is a single-entry output register with no bubble when draining. It is held 0 during reset.
  - Internal state advances only on in_hs.
- **HUNT.**
  - On each in_hs: sr_next = {sr[SYNC_LEN-2:0], bit}.
  - If popcount(sr_next ^ SYNC_WORD) <= MAX_ERR, go to LEN and clear the bit count.
  - The shift register is cleared to 0 when leaving HUNT, so a fresh SYNC_LEN bits are needed after every frame.
- **LEN.**
  - Shift 8 bits MSB-first into len.
  - On the 8th bit: if the length is 0, return to HUNT (frame dropped, no output). Otherwise go to PAYLOAD with byte count = length.
- **PAYLOAD.**
  - Shift bits MSB-first.
  - On the 8th bit of each byte: load tdata[7:0], set m00_axis_tvalid=1 on the next edge, decrement the byte count.
  - Latency is one cycle from the 8th bit's handshake to tvalid.
  - tlast=1 only on the byte where the count reaches 0; the state then returns to HUNT in the same edge.
- **Output register.**
  - m00_axis_tvalid is cleared on out_hs unless a new byte loads in the same cycle. If both happen, the load wins and tvalid stays 1.
  - tdata and tlast are stable while tvalid & ~tready.
- **Edge cases.**
  - Input tlast mid-frame has no effect.
  - Sync-like patterns inside the payload are not searched.
  - A maximum frame (length 255) gives 255 beats.

Optional Feature:
- Macro: SYNC_STATS_EN.
- When defined, adds two outputs:
  - frame_count [15:0]: increments on each nonzero-length frame whose last byte is loaded.
  - drop_count [15:0]: increments on each length-0 header.
- Both counters wrap at 0xFFFF→0 and are reset to 0.
- When undefined, the ports and counters are absent and core behaviour is identical.

Decomposition:
- Package radio_frame_pkg holds:
  - typedef enum logic [1:0] {HUNT, LEN, PAYLOAD} sync_state_t.
  - localparam defaults DEFAULT_SYNC_WORD and DEFAULT_MAX_ERR.
- Sub-module sync_correlator (shift register plus popcount compare, with shift_en, clear and match ports) is the natural split. The top keeps the FSM, packing and AXIS logic.

Test Plan:
- Bits of 1ACFFC1D, 03, A5, 3C, FF with m00_axis_tready=1: three beats 0xA5, 0x3C, 0xFF; tlast on 0xFF only; tstrb=1.
- Sync with 2 bits flipped (0x1ACFFC1C ^ 0x2): locks and the payload is emitted. With 3 flipped bits: no output, still hunting.
- m00_axis_tready low for 20 cycles after the first payload byte: s00_axis_tready drops while that byte is held, tdata stays stable, and all bytes are delivered in order with no loss.
- Length byte 0x00, then a valid frame with length 01 and payload 5A: no beat for the first header; one beat 0x5A with tlast. With SYNC_STATS_EN: drop_count=1, frame_count=1.
- Reset pulsed for 1 cycle mid-payload: tvalid=0 the next cycle. The remaining bits of the old frame produce no output, and the next full frame decodes correctly.
- 200 random bits containing no pattern within distance 2 of the sync word: no m00_axis_tvalid assertion.

Source files
------------

// File: rtl/radio_frame_pkg.sv
// Shared types and defaults for the frame synchroniser / byte packer.
package radio_frame_pkg;

   // Receiver phase: searching for sync, reading the length byte, packing payload.
   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      LEN     = 2'd1,
      PAYLOAD = 2'd2
   } sync_state_t;

   // CCSDS attached sync marker, received MSB first.
   localparam logic [31:0] DEFAULT_SYNC_WORD = 32'h1ACF_FC1D;

   // Bit errors still accepted as a sync hit.
   localparam int DEFAULT_MAX_ERR = 2;

endpackage : radio_frame_pkg

// File: rtl/sync_correlator.sv
// Sliding-window sync correlator: shifts one bit per enable and flags a hit
// when the updated window is within MAX_ERR bit errors of the sync pattern.
// The match is evaluated on the window that includes the incoming bit, so a
// hit is reported in the same cycle as the bit that completes the pattern.
module sync_correlator
   import radio_frame_pkg::*;
#(
   parameter int          SYNC_LEN  = 32,
   parameter logic [31:0] SYNC_WORD = DEFAULT_SYNC_WORD,
   parameter int          MAX_ERR   = DEFAULT_MAX_ERR
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic shift_en_i,
   input  logic clear_i,
   input  logic bit_i,
   output logic match_o
);

   localparam logic [SYNC_LEN-1:0] PATTERN = SYNC_WORD[SYNC_LEN-1:0];

   logic [SYNC_LEN-1:0] sr_q;
   logic [SYNC_LEN-1:0] sr_d;
   logic [SYNC_LEN-1:0] sr_next;
   logic [SYNC_LEN-1:0] diff;
   int                  err_cnt;

   // Candidate window with the new bit appended, and its Hamming distance to the pattern.
   // NOTE: every variable gets a default at the top of a combinational block, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      sr_next = {sr_q[SYNC_LEN-2:0], bit_i};
      diff    = sr_next ^ PATTERN;
      err_cnt = 0;
      for (int i = 0; i < SYNC_LEN; i++) begin
         if (diff[i]) begin
            err_cnt = err_cnt + 1;
         end
      end
   end

   assign match_o = shift_en_i & (err_cnt <= MAX_ERR);

   // Next window: a clear (lock achieved) wins over a shift so every hunt starts from zero.
   always_comb begin
      sr_d = sr_q;
      if (clear_i) begin
         sr_d = '0;
      end else if (shift_en_i) begin
         sr_d = sr_next;
      end
   end

   // Window register with synchronous reset.
   // NOTE: clocked state uses non-blocking assignments so all registers update together from pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

endmodule : sync_correlator

// File: rtl/frame_sync_packer.sv
// Frame synchroniser and byte packer.
// Takes one decoded bit per input beat (tdata[0]), hunts for the sync word
// with bounded bit errors, reads an 8-bit length byte and emits that many
// payload bytes (MSB first) on the output stream, tlast on the final byte.
// The output is a single-entry register; input is stalled while it holds an
// unaccepted byte. s00_axis_aresetn is an active-HIGH synchronous reset.
// Optional build macro SYNC_STATS_EN adds frame_count / drop_count outputs.
module frame_sync_packer
   import radio_frame_pkg::*;
#(
   parameter int          C_S00_AXIS_TDATA_WIDTH = 32,
   parameter int          C_M00_AXIS_TDATA_WIDTH = 32,
   parameter int          SYNC_LEN               = 32,
   parameter logic [31:0] SYNC_WORD              = DEFAULT_SYNC_WORD,
   parameter int          MAX_ERR                = DEFAULT_MAX_ERR
) (
   input  logic                                  s00_axis_aclk,
   input  logic                                  s00_axis_aresetn,
   input  logic                                  s00_axis_tvalid,
   input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
   input  logic [(C_S00_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
   input  logic                                  s00_axis_tlast,
   output logic                                  s00_axis_tready,
   input  logic                                  m00_axis_tready,
   output logic                                  m00_axis_tvalid,
   output logic                                  m00_axis_tlast,
   output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
   output logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb
`ifdef SYNC_STATS_EN
   ,
   output logic [15:0]                           frame_count,
   output logic [15:0]                           drop_count
`endif
);

   localparam int M_STRB_W = C_M00_AXIS_TDATA_WIDTH / 8;

   // Reset is active high in spite of the port name.
   logic rst;
   assign rst = s00_axis_aresetn;

   // Input strobes, input tlast and the unused data bits carry no information here.
   logic unused_inputs;
   assign unused_inputs = ^{s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:1],
                            s00_axis_tstrb, s00_axis_tlast};

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   sync_state_t state_q,    state_d;
   logic [2:0]  bit_cnt_q,  bit_cnt_d;
   logic [7:0]  shift_q,    shift_d;
   logic [7:0]  byte_cnt_q, byte_cnt_d;
   logic        m_valid_q,  m_valid_d;
   logic        m_last_q,   m_last_d;
   logic [7:0]  m_data_q,   m_data_d;

   logic       in_bit;
   logic       in_hs;
   logic       out_hs;
   logic       hunt_shift;
   logic       sync_match;
   logic [7:0] shift_next;
   logic       load;
   logic       load_last;
   logic       drop_hdr;

   assign in_bit = s00_axis_tdata[0];

   // Input is accepted whenever the output register is empty or draining this cycle.
   assign s00_axis_tready = ~rst & (~m_valid_q | m00_axis_tready);
   assign in_hs           = s00_axis_tvalid & s00_axis_tready;
   assign out_hs          = m_valid_q & m00_axis_tready;

   // Correlator only sees bits while hunting; payload is never searched.
   assign hunt_shift = in_hs & (state_q == HUNT);

   sync_correlator #(
      .SYNC_LEN  (SYNC_LEN),
      .SYNC_WORD (SYNC_WORD),
      .MAX_ERR   (MAX_ERR)
   ) u_correlator (
      .clk_i      (s00_axis_aclk),
      .rst_i      (rst),
      .shift_en_i (hunt_shift),
      .clear_i    (sync_match),
      .bit_i      (in_bit),
      .match_o    (sync_match)
   );

   // ---------------------------------------------------------------------------
   // Frame FSM: next state, bit/byte counting and byte-load decisions.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      byte_cnt_d = byte_cnt_q;
      load       = 1'b0;
      load_last  = 1'b0;
      drop_hdr   = 1'b0;
      shift_next = {shift_q[6:0], in_bit};

      if (in_hs) begin
         unique case (state_q)
            HUNT: begin
               if (sync_match) begin
                  state_d   = LEN;
                  bit_cnt_d = 3'd0;
               end
            end

            LEN: begin
               shift_d   = shift_next;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  if (shift_next == 8'd0) begin
                     // Empty frame: nothing to emit, resume the search.
                     state_d  = HUNT;
                     drop_hdr = 1'b1;
                  end else begin
                     state_d    = PAYLOAD;
                     byte_cnt_d = shift_next;
                  end
               end
            end

            PAYLOAD: begin
               shift_d   = shift_next;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  load       = 1'b1;
                  byte_cnt_d = byte_cnt_q - 8'd1;
                  if (byte_cnt_q == 8'd1) begin
                     load_last = 1'b1;
                     state_d   = HUNT;
                  end
               end
            end

            default: begin
               state_d = HUNT;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Output register: a new byte wins over a simultaneous drain.
   // ---------------------------------------------------------------------------
   always_comb begin
      m_valid_d = m_valid_q;
      m_last_d  = m_last_q;
      m_data_d  = m_data_q;
      if (load) begin
         m_valid_d = 1'b1;
         m_last_d  = load_last;
         m_data_d  = shift_next;
      end else if (out_hs) begin
         m_valid_d = 1'b0;
      end
   end

   // State, counters and output beat registers with synchronous reset.
   always_ff @(posedge s00_axis_aclk) begin
      if (rst) begin
         state_q    <= HUNT;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 8'd0;
         byte_cnt_q <= 8'd0;
         m_valid_q  <= 1'b0;
         m_last_q   <= 1'b0;
         m_data_q   <= 8'd0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         byte_cnt_q <= byte_cnt_d;
         m_valid_q  <= m_valid_d;
         m_last_q   <= m_last_d;
         m_data_q   <= m_data_d;
      end
   end

   assign m00_axis_tvalid = m_valid_q;
   assign m00_axis_tlast  = m_last_q;
   assign m00_axis_tdata  = {{(C_M00_AXIS_TDATA_WIDTH-8){1'b0}}, m_data_q};
   assign m00_axis_tstrb  = M_STRB_W'(1);

`ifdef SYNC_STATS_EN
   // ---------------------------------------------------------------------------
   // Link statistics: completed frames and empty headers, both wrapping.
   // ---------------------------------------------------------------------------
   logic [15:0] frame_count_q, frame_count_d;
   logic [15:0] drop_count_q,  drop_count_d;

   // Count a frame when its final byte is loaded, a drop on each zero-length header.
   always_comb begin
      frame_count_d = frame_count_q;
      drop_count_d  = drop_count_q;
      if (load_last) begin
         frame_count_d = frame_count_q + 16'd1;
      end
      if (drop_hdr) begin
         drop_count_d = drop_count_q + 16'd1;
      end
   end

   // Statistics registers with synchronous reset.
   always_ff @(posedge s00_axis_aclk) begin
      if (rst) begin
         frame_count_q <= 16'd0;
         drop_count_q  <= 16'd0;
      end else begin
         frame_count_q <= frame_count_d;
         drop_count_q  <= drop_count_d;
      end
   end

   assign frame_count = frame_count_q;
   assign drop_count  = drop_count_q;
`endif

endmodule : frame_sync_packer

// File: tb/tb_frame_sync_packer.sv
// Self-checking bench for frame_sync_packer: scenario tasks drive bit streams
// and compare delivered output beats against a frame-level reference decoder.
module tb_frame_sync_packer;

   localparam logic [31:0] SYNC    = 32'h1ACF_FC1D;
   localparam int          MAX_ERR = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        s_valid = 1'b0;
   logic [31:0] s_data  = '0;
   logic [3:0]  s_strb  = '0;
   logic        s_last  = 1'b0;
   logic        s_ready;
   logic        m_ready = 1'b1;
   logic        m_valid;
   logic        m_last;
   logic [31:0] m_data;
   logic [3:0]  m_strb;
`ifdef SYNC_STATS_EN
   logic [15:0] frame_count;
   logic [15:0] drop_count;
`endif

   frame_sync_packer dut (
      .s00_axis_aclk    (clk),
      .s00_axis_aresetn (rst),
      .s00_axis_tvalid  (s_valid),
      .s00_axis_tdata   (s_data),
      .s00_axis_tstrb   (s_strb),
      .s00_axis_tlast   (s_last),
      .s00_axis_tready  (s_ready),
      .m00_axis_tready  (m_ready),
      .m00_axis_tvalid  (m_valid),
      .m00_axis_tlast   (m_last),
      .m00_axis_tdata   (m_data),
      .m00_axis_tstrb   (m_strb)
`ifdef SYNC_STATS_EN
      ,
      .frame_count      (frame_count),
      .drop_count       (drop_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        last;
      logic [3:0]  strb;
   } got_t;

   typedef struct {
      logic [7:0] data;
      logic       last;
   } exp_t;

   got_t got_q[$];
   exp_t exp_q[$];
   bit   bit_q[$];

   int checks       = 0;
   int failures     = 0;
   int valid_cycles = 0;
   int rdy_mode     = 0;   // 0: always ready, 1: random, 2: held low

   // Collect accepted output beats, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst && m_valid) begin
         valid_cycles++;
         if (m_ready) got_q.push_back('{m_data, m_last, m_strb});
      end
   end

   // Downstream ready pattern, updated just after each rising edge.
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       m_ready = 1'b1;
         1:       m_ready = ($urandom_range(0, 3) != 0);
         default: m_ready = 1'b0;
      endcase
   end

   initial begin
      #3ms;
      $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Stream building and reference decoder
   // ---------------------------------------------------------------------------
   task automatic push_bits(input logic [31:0] v, input int n);
      for (int k = n - 1; k >= 0; k--) bit_q.push_back(v[k]);
   endtask

   task automatic push_frame(input int len);
      push_bits(SYNC, 32);
      push_bits(32'(len), 8);
      for (int n = 0; n < len; n++) push_bits($urandom_range(0, 255), 8);
   endtask

   // Frame-level decoder: search the last 32 received bits (zeros before the
   // start and after each lock) for a near-sync, then read length and bytes.
   function automatic void run_model();
      logic [31:0] win = '0;
      logic [7:0]  b;
      int          i = 0;
      int          len;
      exp_q.delete();
      while (i < bit_q.size()) begin
         win = {win[30:0], 1'(bit_q[i])};
         i++;
         if ($countones(win ^ SYNC) <= MAX_ERR) begin
            win = '0;
            if (i + 8 > bit_q.size()) begin
               i = bit_q.size();
            end else begin
               len = 0;
               for (int k = 0; k < 8; k++) len = len * 2 + int'(bit_q[i + k]);
               i += 8;
               for (int n = 0; n < len; n++) begin
                  if (i + 8 > bit_q.size()) begin
                     i = bit_q.size();
                     break;
                  end
                  b = '0;
                  for (int k = 0; k < 8; k++) b = {b[6:0], 1'(bit_q[i + k])};
                  i += 8;
                  exp_q.push_back('{b, (n == len - 1)});
               end
            end
         end
      end
   endfunction

   // Drive bit_q with optional idle gaps; bounded by a cycle budget.
   task automatic send_bits(input int gap_pct);
      int i      = 0;
      int budget = bit_q.size() * 40 + 400;
      while (i < bit_q.size()) begin
         @(posedge clk);
         #1;
         budget--;
         if (budget == 0) begin
            checks++;
            failures++;
            $display("FAIL send_timeout sent=%0d required=%0d", i, bit_q.size());
            break;
         end
         if ($urandom_range(0, 99) < gap_pct) begin
            s_valid = 1'b0;
            continue;
         end
         s_valid   = 1'b1;
         s_data    = $urandom();
         s_data[0] = bit_q[i];
         s_strb    = 4'($urandom());
         s_last    = 1'($urandom());
         @(negedge clk);
         if (s_ready) i++;
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (n < 4000 && (got_q.size() < exp_q.size() || m_valid)) begin
         @(negedge clk);
         n++;
      end
      repeat (12) @(negedge clk);
   endtask

   task automatic reset_dut();
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      got_q.delete();
      bit_q.delete();
      valid_cycles = 0;
   endtask

   // ---------------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      rdy_mode = 0;
      rst      = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b0 || m_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_hold tready=%b tvalid=%b required 0/0", s_ready, m_valid);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 32'h0 || m_strb !== 4'b0001 || s_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_state valid=%b last=%b data=%h strb=%b tready=%b required 0/0/0/0001/1",
                  m_valid, m_last, m_data, m_strb, s_ready);
      end
`ifdef SYNC_STATS_EN
      checks++;
      if (frame_count !== 16'd0 || drop_count !== 16'd0) begin
         failures++;
         $display("FAIL reset_stats frame=%0d drop=%0d required 0/0", frame_count, drop_count);
      end
`endif
   endtask

   task automatic test_basic();
      reset_dut();
      push_bits(SYNC, 32);
      push_bits(32'h03, 8);
      push_bits(32'hA5, 8);
      push_bits(32'h3C, 8);
      push_bits(32'hFF, 8);
      exp_q.delete();
      exp_q.push_back('{8'hA5, 1'b0});
      exp_q.push_back('{8'h3C, 1'b0});
      exp_q.push_back('{8'hFF, 1'b1});
      send_bits(0);
      wait_drain();
      checks++;
      if (got_q.size() !== exp_q.size()) begin
         failures++;
         $display("FAIL basic_beats got=%0d required=%0d", got_q.size(), exp_q.size());
      end
      for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
         checks++;
         if (got_q[k].data !== {24'h0, exp_q[k].data} || got_q[k].last !== exp_q[k].last || got_q[k].strb !== 4'b0001) begin
            failures++;
            $display("FAIL basic_beat%0d got=%h/%b/%b required=%h/%b/0001", k,
                     got_q[k].data, got_q[k].last, got_q[k].strb, exp_q[k].data, exp_q[k].last);
         end
      end
   endtask

   task automatic test_sync_errors();
      logic [31:0] flip;
      int          p0, p1, p2;
      // Two flipped bits: must still lock.
      reset_dut();
      p0 = $urandom_range(0, 31);
      p1 = (p0 + $urandom_range(1, 31)) % 32;
      flip = (32'h1 << p0) | (32'h1 << p1);
      push_bits(SYNC ^ flip, 32);
      push_bits(32'h02, 8);
      push_bits($urandom_range(0, 255), 8);
      push_bits($urandom_range(0, 255), 8);
      run_model();
      send_bits(10);
      wait_drain();
      checks++;
      if (got_q.size() !== exp_q.size() || exp_q.size() !== 2) begin
         failures++;
         $display("FAIL err2_beats got=%0d required=%0d", got_q.size(), exp_q.size());
      end
      for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
         checks++;
         if (got_q[k].data !== {24'h0, exp_q[k].data} || got_q[k].last !== exp_q[k].last) begin
            failures++;
            $display("FAIL err2_beat%0d got=%h/%b required=%h/%b", k,
                     got_q[k].data, got_q[k].last, exp_q[k].data, exp_q[k].last);
         end
      end
      // Three flipped bits: no lock; a following clean frame still decodes.
      reset_dut();
      p0 = $urandom_range(0, 9);
      p1 = $urandom_range(10, 20);
      p2 = $urandom_range(21, 31);
      flip = (32'h1 << p0) | (32'h1 << p1) | (32'h1 << p2);
      push_bits(SYNC ^ flip, 32);
      push_bits(32'h03, 8);
      push_bits(32'hC3, 8);
      push_bits(32'h96, 8);
      push_bits(32'h0F, 8);
      run_model();
      send_bits(10);
      wait_drain();
      checks++;
      if (valid_cycles !== 0 || exp_q.size() !== 0) begin
         failures++;
         $display("FAIL err3_no_lock valid_cycles=%0d model_beats=%0d required 0/0", valid_cycles, exp_q.size());
      end
      bit_q.delete();
      push_bits(SYNC, 32);
      push_bits(32'h01, 8);
      push_bits(32'h5A, 8);
      send_bits(0);
      wait_drain();
      checks++;
      if (got_q.size() !== 1 || got_q[0].data !== 32'h5A || got_q[0].last !== 1'b1) begin
         failures++;
         $display("FAIL err3_relock beats=%0d required 1 beat 5a with tlast", got_q.size());
      end
   endtask

   task automatic test_backpressure();
      reset_dut();
      rdy_mode = 2;
      push_frame(4);
      run_model();
      fork
         send_bits(0);
         begin
            logic [31:0] held;
            int          n = 0;
            while (!m_valid && n < 2000) begin
               @(negedge clk);
               n++;
            end
            checks++;
            if (m_valid !== 1'b1) begin
               failures++;
               $display("FAIL bp_first_valid got=%b required=1", m_valid);
            end
            held = m_data;
            repeat (20) begin
               @(negedge clk);
               checks++;
               if (m_valid !== 1'b1 || s_ready !== 1'b0 || m_data !== held) begin
                  failures++;
                  $display("FAIL bp_hold valid=%b tready=%b data=%h required 1/0/%h", m_valid, s_ready, m_data, held);
               end
            end
            rdy_mode = 0;
         end
      join
      wait_drain();
      checks++;
      if (got_q.size() !== exp_q.size()) begin
         failures++;
         $display("FAIL bp_beats got=%0d required=%0d", got_q.size(), exp_q.size());
      end
      for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
         checks++;
         if (got_q[k].data !== {24'h0, exp_q[k].data} || got_q[k].last !== exp_q[k].last) begin
            failures++;
            $display("FAIL bp_beat%0d got=%h/%b required=%h/%b", k,
                     got_q[k].data, got_q[k].last, exp_q[k].data, exp_q[k].last);
         end
      end
   endtask

   task automatic test_zero_len();
      reset_dut();
      push_bits(SYNC, 32);
      push_bits(32'h00, 8);
      push_bits(SYNC, 32);
      push_bits(32'h01, 8);
      push_bits(32'h5A, 8);
      send_bits(0);
      wait_drain();
      checks++;
      if (got_q.size() !== 1) begin
         failures++;
         $display("FAIL zero_len_beats got=%0d required=1", got_q.size());
      end else begin
         checks++;
         if (got_q[0].data !== 32'h5A || got_q[0].last !== 1'b1) begin
            failures++;
            $display("FAIL zero_len_beat got=%h/%b required=0000005a/1", got_q[0].data, got_q[0].last);
         end
      end
`ifdef SYNC_STATS_EN
      checks++;
      if (frame_count !== 16'd1 || drop_count !== 16'd1) begin
         failures++;
         $display("FAIL zero_len_stats frame=%0d drop=%0d required 1/1", frame_count, drop_count);
      end
`endif
   endtask

   task automatic test_reset_mid();
      reset_dut();
      rdy_mode = 2;
      push_bits(SYNC, 32);
      push_bits(32'h04, 8);
      push_bits($urandom_range(0, 255), 8);
      send_bits(0);
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_held got=%b required=1", m_valid);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 32'h0) begin
         failures++;
         $display("FAIL rstmid_cleared valid=%b last=%b data=%h required 0/0/0", m_valid, m_last, m_data);
      end
      @(posedge clk);
      #1;
      rst      = 1'b0;
      rdy_mode = 0;
      got_q.delete();
      bit_q.delete();
      for (int n = 0; n < 3; n++) push_bits($urandom_range(0, 255), 8);
      push_frame(3);
      run_model();
      send_bits(10);
      wait_drain();
      checks++;
      if (got_q.size() !== exp_q.size()) begin
         failures++;
         $display("FAIL rstmid_beats got=%0d required=%0d", got_q.size(), exp_q.size());
      end
      for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
         checks++;
         if (got_q[k].data !== {24'h0, exp_q[k].data} || got_q[k].last !== exp_q[k].last) begin
            failures++;
            $display("FAIL rstmid_beat%0d got=%h/%b required=%h/%b", k,
                     got_q[k].data, got_q[k].last, exp_q[k].data, exp_q[k].last);
         end
      end
   endtask

   task automatic test_noise();
      logic [31:0] win;
      bit          near;
      reset_dut();
      do begin
         bit_q.delete();
         for (int n = 0; n < 200; n++) bit_q.push_back(1'($urandom()));
         win  = '0;
         near = 1'b0;
         foreach (bit_q[n]) begin
            win = {win[30:0], 1'(bit_q[n])};
            if ($countones(win ^ SYNC) <= MAX_ERR) near = 1'b1;
         end
      end while (near);
      send_bits(15);
      repeat (20) @(negedge clk);
      checks++;
      if (valid_cycles !== 0 || got_q.size() !== 0) begin
         failures++;
         $display("FAIL noise_no_output valid_cycles=%0d beats=%0d required 0/0", valid_cycles, got_q.size());
      end
   endtask

   task automatic test_random_frames();
      int n_last = 0;
      reset_dut();
      rdy_mode = 1;
      for (int f = 0; f < 6; f++) begin
         repeat ($urandom_range(0, 20)) bit_q.push_back(1'($urandom()));
         push_frame($urandom_range(1, 16));
      end
      push_frame(255);
      run_model();
      send_bits(15);
      wait_drain();
      rdy_mode = 0;
      checks++;
      if (got_q.size() !== exp_q.size()) begin
         failures++;
         $display("FAIL rand_beats got=%0d required=%0d", got_q.size(), exp_q.size());
      end
      for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
         checks++;
         if (got_q[k].data !== {24'h0, exp_q[k].data} || got_q[k].last !== exp_q[k].last || got_q[k].strb !== 4'b0001) begin
            failures++;
            $display("FAIL rand_beat%0d got=%h/%b/%b required=%h/%b/0001", k,
                     got_q[k].data, got_q[k].last, got_q[k].strb, exp_q[k].data, exp_q[k].last);
         end
      end
      foreach (exp_q[k]) if (exp_q[k].last) n_last++;
`ifdef SYNC_STATS_EN
      checks++;
      if (int'(frame_count) !== n_last) begin
         failures++;
         $display("FAIL rand_frame_count got=%0d required=%0d", frame_count, n_last);
      end
`else
      checks++;
      if (n_last < 7) begin
         failures++;
         $display("FAIL rand_model_frames got=%0d required>=7", n_last);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_sync_errors();
      test_backpressure();
      test_zero_len();
      test_reset_mid();
      test_noise();
      test_random_frames();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_frame_sync_packer
